// File: rtl/mac_tx_sequencer.sv
// MAC TX frame sequencer: selects header/data/idle/IFG/error words for the frame
// generator and pops the TX frame buffer during the data phase.
module mac_tx_sequencer #(
  parameter int HDR_BEATS     = 1,
  parameter int W_MAC_HDR_CNT = 1,
  parameter int IFG_BEATS     = 2,
  parameter int MAX_BEATS     = 190,
  parameter int W_BEAT_CNT    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clk_en,
  input  logic                     i_frame_avail,
  input  logic                     i_buf_empty,
  input  logic                     i_buf_last,
  output logic                     o_buf_ren,
  output logic                     o_gen_hdr,
  output logic [W_MAC_HDR_CNT-1:0] o_hdr_id,
  output logic                     o_gen_data,
  output logic                     o_gen_idle,
  output logic                     o_gen_ifg,
  output logic                     o_gen_error,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_abort
);

  localparam int W_IFG_CNT = (IFG_BEATS > 1) ? $clog2(IFG_BEATS) : 1;

  localparam logic [W_MAC_HDR_CNT-1:0] HDR_LAST  = W_MAC_HDR_CNT'(HDR_BEATS - 1);
  localparam logic [W_BEAT_CNT-1:0]    BEAT_LAST = W_BEAT_CNT'(MAX_BEATS - 1);
  localparam logic [W_IFG_CNT-1:0]     IFG_LAST  = W_IFG_CNT'(IFG_BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_ERR,
    ST_IFG
  } state_e;

  state_e                   state_q, state_d;
  logic [W_MAC_HDR_CNT-1:0] hdrCnt_q, hdrCnt_d;
  logic [W_BEAT_CNT-1:0]    beatCnt_q, beatCnt_d;
  logic [W_IFG_CNT-1:0]     ifgCnt_q, ifgCnt_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      hdrCnt_q  <= '0;
      beatCnt_q <= '0;
      ifgCnt_q  <= '0;
    end else if (i_clk_en) begin
      state_q   <= state_d;
      hdrCnt_q  <= hdrCnt_d;
      beatCnt_q <= beatCnt_d;
      ifgCnt_q  <= ifgCnt_d;
    end
  end

  // Pops and pulses are suppressed while reset is asserted so a frame cut off
  // by reset leaves the buffer untouched.
  always_comb begin
    state_d      = state_q;
    hdrCnt_d     = hdrCnt_q;
    beatCnt_d    = beatCnt_q;
    ifgCnt_d     = ifgCnt_q;
    o_buf_ren    = 1'b0;
    o_frame_done = 1'b0;
    o_abort      = 1'b0;
    if (i_clk_en && !i_reset) begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_avail) begin
            state_d  = ST_HDR;
            hdrCnt_d = '0;
          end
        end
        ST_HDR: begin
          if (hdrCnt_q == HDR_LAST) begin
            state_d   = ST_DATA;
            beatCnt_d = '0;
          end else begin
            hdrCnt_d = hdrCnt_q + W_MAC_HDR_CNT'(1);
          end
        end
        ST_DATA: begin
          if (i_buf_empty) begin
            o_abort = 1'b1;
            state_d = ST_ERR;
          end else begin
            o_buf_ren = 1'b1;
            beatCnt_d = beatCnt_q + W_BEAT_CNT'(1);
            if (i_buf_last) begin
              o_frame_done = 1'b1;
              state_d      = ST_IFG;
              ifgCnt_d     = '0;
            end else if (beatCnt_q == BEAT_LAST) begin
              o_abort = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
        ST_ERR: begin
          state_d  = ST_IFG;
          ifgCnt_d = '0;
        end
        ST_IFG: begin
          if (ifgCnt_q == IFG_LAST) begin
            if (i_frame_avail) begin
              state_d  = ST_HDR;
              hdrCnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ifgCnt_d = ifgCnt_q + W_IFG_CNT'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_gen_idle  = (state_q == ST_IDLE);
  assign o_gen_hdr   = (state_q == ST_HDR);
  assign o_gen_data  = (state_q == ST_DATA);
  assign o_gen_error = (state_q == ST_ERR);
  assign o_gen_ifg   = (state_q == ST_IFG);
  assign o_hdr_id    = (state_q == ST_HDR) ? hdrCnt_q : '0;
  assign o_busy      = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_ERR);

endmodule

// File: tb/tb_mac_tx_sequencer.sv
// Bench for mac_tx_sequencer: directed frame scenarios with literal strobe
// sequences, then randomized traffic checked every cycle against a beat-plan model.
module tb_mac_tx_sequencer;

  localparam int HDR_BEATS = 2;
  localparam int W_HDR     = 1;
  localparam int IFG_BEATS = 2;
  localparam int MAX_BEATS = 4;
  localparam int W_BEAT    = 3;
  localparam int VW        = 9 + W_HDR;

  localparam int K_IDLE = 0;
  localparam int K_HDR  = 1;
  localparam int K_DATA = 2;
  localparam int K_ERR  = 3;
  localparam int K_IFG  = 4;

  typedef struct {
    int kind;
    int id;
  } beat_t;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_clk_en = 1'b0;
  logic             i_frame_avail = 1'b0;
  logic             i_buf_empty = 1'b1;
  logic             i_buf_last = 1'b0;
  logic             o_buf_ren, o_gen_hdr, o_gen_data, o_gen_idle, o_gen_ifg, o_gen_error;
  logic             o_busy, o_frame_done, o_abort;
  logic [W_HDR-1:0] o_hdr_id;

  mac_tx_sequencer #(
    .HDR_BEATS(HDR_BEATS), .W_MAC_HDR_CNT(W_HDR), .IFG_BEATS(IFG_BEATS),
    .MAX_BEATS(MAX_BEATS), .W_BEAT_CNT(W_BEAT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
    .i_frame_avail(i_frame_avail), .i_buf_empty(i_buf_empty), .i_buf_last(i_buf_last),
    .o_buf_ren(o_buf_ren), .o_gen_hdr(o_gen_hdr), .o_hdr_id(o_hdr_id),
    .o_gen_data(o_gen_data), .o_gen_idle(o_gen_idle), .o_gen_ifg(o_gen_ifg),
    .o_gen_error(o_gen_error), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    popCount = 0;
  int    doneCount = 0;
  int    abortCount = 0;
  int    renOff = 0;
  string modelLog = "";
  string dutLog = "";
  bit    modelValid = 1'b0;

  // The model is a plan of upcoming enabled beats; data beats are open-ended
  // and resolved from the buffer inputs as they arrive.
  beat_t plan[$];
  bit    inData = 1'b0;
  int    dataBeats = 0;

  beat_t          cur;
  bit             lastIfg;
  bit             en, expRen, expDone, expAbort, expBusy;
  logic [4:0]     expGen;
  logic [VW-1:0]  expVec, actVec;

  function automatic beat_t curBeat();
    beat_t b;
    if (plan.size() > 0) return plan[0];
    b.kind = inData ? K_DATA : K_IDLE;
    b.id   = 0;
    return b;
  endfunction

  function automatic string kindChar(int k);
    case (k)
      K_IDLE:  return "I";
      K_HDR:   return "H";
      K_DATA:  return "D";
      K_ERR:   return "E";
      K_IFG:   return "G";
      default: return "?";
    endcase
  endfunction

  function automatic string dutChar();
    case ({o_gen_idle, o_gen_hdr, o_gen_data, o_gen_error, o_gen_ifg})
      5'b10000: return "I";
      5'b01000: return "H";
      5'b00100: return "D";
      5'b00010: return "E";
      5'b00001: return "G";
      default:  return "?";
    endcase
  endfunction

  function automatic bit bitAt(string s, int i);
    return s[i] == "1";
  endfunction

  task automatic pushGap();
    for (int g = 0; g < IFG_BEATS; g++) plan.push_back('{K_IFG, 0});
  endtask

  always begin
    @(posedge i_clk);
    #8;
    if (modelValid) begin
      cur      = curBeat();
      en       = i_clk_en && !i_reset;
      expRen   = en && (cur.kind == K_DATA) && !i_buf_empty;
      expDone  = expRen && i_buf_last;
      expAbort = en && (cur.kind == K_DATA) &&
                 (i_buf_empty || (!i_buf_last && dataBeats == MAX_BEATS - 1));
      expGen   = {cur.kind == K_IDLE, cur.kind == K_HDR, cur.kind == K_DATA,
                  cur.kind == K_ERR, cur.kind == K_IFG};
      expBusy  = (cur.kind == K_HDR) || (cur.kind == K_DATA) || (cur.kind == K_ERR);
      expVec   = {expGen, W_HDR'((cur.kind == K_HDR) ? cur.id : 0),
                  expRen, expDone, expAbort, expBusy};
      actVec   = {o_gen_idle, o_gen_hdr, o_gen_data, o_gen_error, o_gen_ifg, o_hdr_id,
                  o_buf_ren, o_frame_done, o_abort, o_busy};
      vectors++;
      if (actVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL cycle at %0t: got %b, want %b (idle,hdr,data,err,ifg,id,ren,done,abort,busy)",
                 $time, actVec, expVec);
      end
      if (!i_reset) begin
        modelLog = {modelLog, kindChar(cur.kind)};
        dutLog   = {dutLog, dutChar()};
      end
    end
    if (o_buf_ren === 1'b1) popCount++;
    if (o_frame_done === 1'b1) doneCount++;
    if (o_abort === 1'b1) abortCount++;
    if (o_buf_ren === 1'b1 && !i_clk_en) renOff++;

    if (i_reset) begin
      plan.delete();
      inData     = 1'b0;
      dataBeats  = 0;
      modelValid = 1'b1;
    end else if (modelValid && i_clk_en) begin
      cur     = curBeat();
      lastIfg = (cur.kind == K_IFG) && (plan.size() == 1);
      if (plan.size() > 0) void'(plan.pop_front());
      if (cur.kind == K_DATA) begin
        if (i_buf_empty) begin
          plan.push_back('{K_ERR, 0});
          pushGap();
          inData = 1'b0;
        end else begin
          dataBeats++;
          if (i_buf_last) begin
            pushGap();
            inData = 1'b0;
          end else if (dataBeats == MAX_BEATS) begin
            plan.push_back('{K_ERR, 0});
            pushGap();
            inData = 1'b0;
          end
        end
      end
      if ((cur.kind == K_IDLE || lastIfg) && i_frame_avail) begin
        for (int h = 0; h < HDR_BEATS; h++) plan.push_back('{K_HDR, h});
        inData    = 1'b1;
        dataBeats = 0;
      end
    end
  end

  task automatic applyStimulus(input bit rs, input bit av, input bit em, input bit la,
                               input bit ce);
    @(posedge i_clk);
    #2;
    i_reset       = rs;
    i_frame_avail = av;
    i_buf_empty   = em;
    i_buf_last    = la;
    i_clk_en      = ce;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic checkString(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, want %s", name, act, exp);
    end
  endtask

  task automatic runSeq(input string name, input string av, input string em,
                        input string la, input string ce, input string rs,
                        input string expKinds, input int expPops, input int expDone,
                        input int expAbort);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    modelLog   = "";
    dutLog     = "";
    popCount   = 0;
    doneCount  = 0;
    abortCount = 0;
    renOff     = 0;
    for (int i = 0; i < av.len(); i++)
      applyStimulus(bitAt(rs, i), bitAt(av, i), bitAt(em, i), bitAt(la, i), bitAt(ce, i));
    #7;
    checkString({name, " model strobes"}, modelLog, expKinds);
    checkString({name, " dut strobes"}, dutLog, expKinds);
    checkOutput({name, " pops"}, popCount, expPops);
    checkOutput({name, " frame_done"}, doneCount, expDone);
    checkOutput({name, " abort"}, abortCount, expAbort);
    checkOutput({name, " ren while clk_en low"}, renOff, 0);
  endtask

  initial begin
    $display("[TB] mac_tx_sequencer bench start");

    runSeq("b2b+underrun", "1000000100000000", "0000000000010000", "0000010000000000",
           "1111111111111111", "0000000000000000", "IHHDDDGGHHDDEGGI", 4, 1, 1);
    runSeq("oversize", "10000000000", "00000000000", "00000000000",
           "11111111111", "00000000000", "IHHDDDDEGGI", 4, 0, 1);
    runSeq("last on max beat", "1000000000", "0000000000", "0000001000",
           "1111111111", "0000000000", "IHHDDDDGGI", 4, 1, 0);
    runSeq("clk_en toggling", "10000000000000000", "00000000000000000",
           "00000000001000000", "10101010101010101", "00000000000000000",
           "IHHHHDDDDDDGGGGII", 3, 1, 0);
    runSeq("reset in data", "100000", "000000", "000000", "111111", "000010",
           "IHHDI", 1, 0, 0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    renOff = 0;
    for (int n = 0; n < 4000; n++)
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) < 8);
    #7;
    checkOutput("random ren while clk_en low", renOff, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_tx_sequencer.md
Name: mac_tx_sequencer

Overview:
- Control FSM that drives the MAC TX frame generator's select inputs: header/data/idle/IFG/error strobes and header beat index.
- Pops words from the TX frame buffer during the data phase, one per enabled cycle.
- Enforces inter-frame gap, buffer-underrun abort and maximum-frame-length abort.
- Sits between the TX frame buffer (show-ahead FIFO: head word valid whenever not empty) and the frame generator; both share i_clk/i_clk_en.

Parameters:
- HDR_BEATS, 1: header beats per frame (preamble+SFD words).
- W_MAC_HDR_CNT, 1: width of header beat index; must hold HDR_BEATS-1.
- IFG_BEATS, 2: minimum idle beats after the terminate word.
- MAX_BEATS, 190: max data beats per frame before abort.
- W_BEAT_CNT, 8: data beat counter width; must hold MAX_BEATS.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high (clock i_clk).
- i_clk_en  in  1  cycle qualifier; FSM, counters and pops advance only when high.
- i_frame_avail  in  1  buffer holds at least one complete frame.
- i_buf_empty  in  1  buffer empty.
- i_buf_last  in  1  head word carries the terminate symbol.
- o_buf_ren  out  1  pop head word (combinational).
- o_gen_hdr  out  1  select header.
- o_hdr_id  out  W_MAC_HDR_CNT  header beat index.
- o_gen_data  out  1  select buffer data.
- o_gen_idle  out  1  select idle.
- o_gen_ifg  out  1  select IFG idle.
- o_gen_error  out  1  select error word.
- o_busy  out  1  high in HDR, DATA or ERR.
- o_frame_done  out  1  one-cycle pulse on clean end-of-frame.
- o_abort  out  1  one-cycle pulse on underrun or oversize abort.

Behaviour:
- States: IDLE, HDR, DATA, ERR, IFG; state register updates only when i_clk_en=1.
- Reset: state=IDLE, hdr/beat/ifg counters=0.
  - Outputs after reset: o_gen_idle=1, all other o_gen_*=0, o_hdr_id=0, o_buf_ren=0, o_busy=0, pulses=0.
  - Reset mid-frame abandons the frame without emitting an error word; buffer words are not popped.
- o_gen_* and o_hdr_id are Moore decodes of state/counters, exactly one-hot across the five strobes.
- IDLE:
  - o_gen_idle=1.
  - If i_frame_avail=1 on an enabled cycle, go to HDR with hdr_cnt=0.
- HDR:
  - o_gen_hdr=1, o_hdr_id=hdr_cnt.
  - hdr_cnt increments per enabled cycle.
  - At hdr_cnt==HDR_BEATS-1, go to DATA with beat_cnt=0.
- DATA: o_gen_data=1. On each enabled cycle:
  - i_buf_empty=1 (underrun): no pop; o_abort pulse; go to ERR.
  - else o_buf_ren=1 and beat_cnt++.
  - If i_buf_last=1: o_frame_done pulse, go to IFG with ifg_cnt=0.
  - Else if beat_cnt==MAX_BEATS-1: o_abort pulse, go to ERR.
  - Precedence: empty > last > oversize. last on beat MAX_BEATS-1 is a clean frame.
- ERR:
  - o_gen_error=1 for exactly one enabled cycle, then IFG.
  - On oversize abort, the rest of the frame stays in the buffer; the upstream flush is triggered by o_abort.
- IFG:
  - o_gen_ifg=1; ifg_cnt increments per enabled cycle.
  - At ifg_cnt==IFG_BEATS-1: go to HDR if i_frame_avail=1 (back-to-back frames, no IDLE beat), else IDLE.
- o_buf_ren = (state==DATA) & ~i_buf_empty & i_clk_en. Pulses are qualified by i_clk_en.
- i_clk_en=0: state and counters hold, o_gen_*/o_hdr_id hold their values, o_buf_ren=0, pulses=0.
- Latency: strobe change appears one cycle after the enabled transition; the generator adds one register. Buffer data must be consumed the cycle o_buf_ren=1.

Test Plan:
- 3-word frame (last on word 3), clk_en=1: IDLE, HDR(id 0), DATA×3 with ren×3, frame_done on 3rd beat, IFG×2, IDLE. Strobes one-hot every cycle.
- Back-to-back: frame_avail held high at end of IFG -> HDR directly after 2 IFG beats, no gen_idle beat between frames.
- Underrun: buf_empty=1 on 2nd data beat -> no ren, abort pulse, one gen_error beat, IFG×2, IDLE; total pops=1.
- Oversize: MAX_BEATS=4, no last -> 4 pops, abort on beat 4, gen_error×1, IFG. Variant with last on beat 4 -> frame_done, no abort.
- clk_en toggling 1/0 during a 3-word frame -> identical strobe sequence over enabled cycles; ren never high when clk_en=0.
- Reset asserted in DATA -> next cycle gen_idle=1, busy=0, no error beat, no ren.
